// File: rtl/vga_pkg.sv
// Shared constants, write_reg field layout and writer state encoding for the VGA write path.
package vga_pkg;

    localparam int unsigned H_PIXELS     = 640;
    localparam int unsigned V_LINES      = 480;
    localparam int unsigned FRAME_PIXELS = H_PIXELS * V_LINES;
    localparam int unsigned ADDR_W       = 20;
    localparam int unsigned PIX_W        = 4;

    // write_reg layout: [19:0] address, [23:20] data, [24] strobe, [31:25] zero
    localparam int unsigned WR_REG_W      = 32;
    localparam int unsigned WR_ADDR_LSB   = 0;
    localparam int unsigned WR_ADDR_MSB   = 19;
    localparam int unsigned WR_DATA_LSB   = 20;
    localparam int unsigned WR_DATA_MSB   = 23;
    localparam int unsigned WR_STROBE_BIT = 24;

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_WRITE    = 2'd1,
        ST_DONE     = 2'd2
    } writer_state_t;

endpackage

// File: rtl/vga_write_addr_gen.sv
// Column/row counters plus an incrementally maintained linear frame address.
module vga_write_addr_gen #(
    parameter int unsigned H_PIXELS = vga_pkg::H_PIXELS,
    parameter int unsigned V_LINES  = vga_pkg::V_LINES,
    parameter int unsigned ADDR_W   = vga_pkg::ADDR_W
) (
    input  logic              sys_clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              load_zero,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              last_pixel
);

    localparam int unsigned COL_W = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int unsigned ROW_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;

    logic [COL_W-1:0]  col, col_n, base_col;
    logic [ROW_W-1:0]  row, row_n, base_row;
    logic [ADDR_W-1:0] addr_n, base_addr;

    assign last_pixel = (col == COL_W'(H_PIXELS - 1)) && (row == ROW_W'(V_LINES - 1));

    // load_zero steps from position 0, so the counters land on 1 after the SOF pixel
    always_comb begin
        base_col  = load_zero ? '0 : col;
        base_row  = load_zero ? '0 : row;
        base_addr = load_zero ? '0 : addr;
        col_n     = col;
        row_n     = row;
        addr_n    = addr;
        if (clear) begin
            col_n  = '0;
            row_n  = '0;
            addr_n = '0;
        end else if (load_zero || advance) begin
            addr_n = base_addr + ADDR_W'(1);
            if (base_col == COL_W'(H_PIXELS - 1)) begin
                col_n = '0;
                row_n = (base_row == ROW_W'(V_LINES - 1)) ? '0 : base_row + ROW_W'(1);
            end else begin
                col_n = base_col + COL_W'(1);
                row_n = base_row;
            end
        end
    end

    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else begin
            col  <= col_n;
            row  <= row_n;
            addr <= addr_n;
        end
    end

endmodule

// File: rtl/vga_frame_writer.sv
// Pixel stream to VGA memory write port with frame tracking.
// Optional VGA_FRAME_CHECK_EN: SOF inside a frame flags frame_err and restarts at address 0.
module vga_frame_writer #(
    parameter int unsigned H_PIXELS = vga_pkg::H_PIXELS,
    parameter int unsigned V_LINES  = vga_pkg::V_LINES,
    parameter int unsigned ADDR_W   = vga_pkg::ADDR_W,
    parameter int unsigned PIX_W    = vga_pkg::PIX_W
) (
    input  logic                          sys_clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PIX_W-1:0]              in_pixel,
    input  logic                          in_sof,
    input  logic                          err_clear,
    output logic [vga_pkg::WR_REG_W-1:0]  write_reg,
    output logic                          frame_done,
    output logic                          frame_err,
    output logic                          busy
);

    localparam int unsigned A_LSB = vga_pkg::WR_ADDR_LSB;
    localparam int unsigned A_MSB = vga_pkg::WR_ADDR_MSB;
    localparam int unsigned D_LSB = vga_pkg::WR_DATA_LSB;
    localparam int unsigned D_MSB = vga_pkg::WR_DATA_MSB;
    localparam int unsigned S_BIT = vga_pkg::WR_STROBE_BIT;
    localparam int unsigned WA_W  = A_MSB - A_LSB + 1;
    localparam int unsigned WD_W  = D_MSB - D_LSB + 1;

    vga_pkg::writer_state_t state, state_next;

    logic              beat;
    logic              restart;
    logic              load_zero;
    logic              advance;
    logic              gen_clear;
    logic              do_write;
    logic              last_pixel;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] wr_addr;

    // ready depends on state only, so the beat is formed without going through in_ready
    assign beat    = in_valid && (state != vga_pkg::ST_DONE);
    assign wr_addr = load_zero ? '0 : cur_addr;

`ifdef VGA_FRAME_CHECK_EN
    assign restart = (state == vga_pkg::ST_WRITE) && beat && in_sof;
`else
    assign restart = 1'b0;
`endif

    vga_write_addr_gen #(
        .H_PIXELS (H_PIXELS),
        .V_LINES  (V_LINES),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .sys_clock  (sys_clock),
        .reset      (reset),
        .clear      (gen_clear),
        .load_zero  (load_zero),
        .advance    (advance),
        .addr       (cur_addr),
        .last_pixel (last_pixel)
    );

    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            state <= vga_pkg::ST_WAIT_SOF;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            vga_pkg::ST_WAIT_SOF: if (beat && in_sof) state_next = vga_pkg::ST_WRITE;
            vga_pkg::ST_WRITE:    if (beat && !restart && last_pixel) state_next = vga_pkg::ST_DONE;
            vga_pkg::ST_DONE:     state_next = vga_pkg::ST_WAIT_SOF;
            default:              state_next = vga_pkg::ST_WAIT_SOF;
        endcase
    end

    always_comb begin
        in_ready  = 1'b1;
        busy      = 1'b0;
        load_zero = 1'b0;
        advance   = 1'b0;
        gen_clear = 1'b0;
        do_write  = 1'b0;
        case (state)
            vga_pkg::ST_WAIT_SOF: begin
                if (beat && in_sof) begin
                    load_zero = 1'b1;
                    do_write  = 1'b1;
                end
            end
            vga_pkg::ST_WRITE: begin
                busy = 1'b1;
                if (beat) begin
                    do_write  = 1'b1;
                    load_zero = restart;
                    advance   = !restart;
                end
            end
            vga_pkg::ST_DONE: begin
                in_ready  = 1'b0;
                gen_clear = 1'b1;
            end
            default: ;
        endcase
    end

    // Address/data fields hold between writes; only the strobe drops
    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            write_reg  <= '0;
            frame_done <= 1'b0;
        end else begin
            write_reg[S_BIT] <= do_write;
            if (do_write) begin
                write_reg[A_MSB:A_LSB] <= WA_W'(wr_addr);
                write_reg[D_MSB:D_LSB] <= WD_W'(in_pixel);
            end
            frame_done <= (state == vga_pkg::ST_WRITE) && beat && !restart && last_pixel;
        end
    end

`ifdef VGA_FRAME_CHECK_EN
    // Set wins over a same-cycle clear
    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            frame_err <= 1'b0;
        end else if (restart) begin
            frame_err <= 1'b1;
        end else if (err_clear) begin
            frame_err <= 1'b0;
        end
    end
`else
    logic unused_err_clear;
    assign unused_err_clear = err_clear;
    assign frame_err        = 1'b0;
`endif

endmodule

// File: tb/tb_vga_frame_writer.sv
// Directed bench for vga_frame_writer on a reduced 80x80 raster.
module tb_vga_frame_writer;

    localparam int unsigned H     = 80;
    localparam int unsigned V     = 80;
    localparam int unsigned FRAME = H * V;

    logic        sys_clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_pixel;
    logic        in_sof;
    logic        err_clear;
    logic [31:0] write_reg;
    logic        frame_done;
    logic        frame_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        valid;
        logic        sof;
        logic [3:0]  pixel;
        logic        exp_strobe;
        logic [19:0] exp_addr;
        logic [3:0]  exp_data;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[6];

    vga_frame_writer #(
        .H_PIXELS (H),
        .V_LINES  (V),
        .ADDR_W   (20),
        .PIX_W    (4)
    ) dut (
        .sys_clock  (sys_clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .in_sof     (in_sof),
        .err_clear  (err_clear),
        .write_reg  (write_reg),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wr(input logic s, input logic [19:0] a, input logic [3:0] d);
        return {7'b0, s, d, a};
    endfunction

    task automatic step();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [3:0] p);
        in_valid = v;
        in_sof   = s;
        in_pixel = p;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 4'h0);
        err_clear = 1'b0;
        reset     = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_write_reg"}, write_reg, 32'h0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'h0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'h1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [19:0] exp_a;
        logic        exp_err;
        logic        v;
        logic        s;
        logic [3:0]  p;
        int          k;
        int          cycles;

        // valid, sof, pixel -> strobe, addr, data, busy (seen after the edge)
        vecs[0] = '{1'b1, 1'b0, 4'h5, 1'b0, 20'd0, 4'h0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 4'h7, 1'b0, 20'd0, 4'h0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 4'h9, 1'b1, 20'd0, 4'h9, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 4'h3, 1'b1, 20'd1, 4'h3, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 4'hF, 1'b0, 20'd1, 4'h3, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 4'hA, 1'b1, 20'd2, 4'hA, 1'b1};

        reset     = 1'b1;
        err_clear = 1'b0;
        drive(1'b0, 1'b0, 4'h0);
        #2;
        do_reset();
        #1;
        check_reset_values("reset");

        // Beats without SOF are dropped while waiting for a frame
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 4'(i + 1));
            step();
            check("nosof_write_reg", write_reg, 32'h0);
            check("nosof_busy", 32'(busy), 32'h0);
        end

        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].valid, vecs[i].sof, vecs[i].pixel);
            step();
            check($sformatf("vec%0d_write_reg", i), write_reg,
                  wr(vecs[i].exp_strobe, vecs[i].exp_addr, vecs[i].exp_data));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'h1);
        end

        // Full frame, back to back
        do_reset();
        for (int i = 0; i < int'(FRAME); i++) begin
            drive(1'b1, i == 0, 4'(i));
            step();
            check("frame_write", write_reg, wr(1'b1, 20'(i), 4'(i)));
            check("frame_done", 32'(frame_done), 32'(i == int'(FRAME) - 1));
            check("frame_in_ready", 32'(in_ready), 32'(i != int'(FRAME) - 1));
        end
        drive(1'b1, 1'b0, 4'h6);
        step();
        check("after_done_write_reg", write_reg, wr(1'b0, 20'(FRAME - 1), 4'(FRAME - 1)));
        check("after_done_pulse", 32'(frame_done), 32'h0);
        check("after_done_in_ready", 32'(in_ready), 32'h1);
        check("after_done_busy", 32'(busy), 32'h0);
        step();
        check("wait_drop_strobe", 32'(write_reg[24]), 32'h0);
        drive(1'b1, 1'b1, 4'h5);
        step();
        check("next_frame_write", write_reg, wr(1'b1, 20'd0, 4'h5));

        // Random valid gaps with an SOF on pixel 1000
        do_reset();
        k       = 0;
        cycles  = 0;
        exp_a   = 20'd0;
        exp_err = 1'b0;
        while (k < 2000 && cycles < 20000) begin
            v = 1'($urandom_range(0, 1));
            p = 4'($urandom_range(0, 15));
            s = (k == 0) || (k == 1000);
            drive(v, s, p);
            step();
            cycles++;
            if (v) begin
                if (k == 1000) begin
`ifdef VGA_FRAME_CHECK_EN
                    exp_a   = 20'd0;
                    exp_err = 1'b1;
`endif
                end
                check("rand_write", write_reg, wr(1'b1, exp_a, p));
                check("rand_frame_err", 32'(frame_err), 32'(exp_err));
                exp_a = exp_a + 20'd1;
                k++;
            end else begin
                check("rand_idle_strobe", 32'(write_reg[24]), 32'h0);
            end
        end
        check("rand_beat_count", 32'(k), 32'd2000);

        drive(1'b0, 1'b0, 4'h0);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("err_clear", 32'(frame_err), 32'h0);

        drive(1'b1, 1'b1, 4'h7);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
`ifdef VGA_FRAME_CHECK_EN
        check("sof_set_wins_write", write_reg, wr(1'b1, 20'd0, 4'h7));
        check("sof_set_wins_err", 32'(frame_err), 32'h1);
`else
        check("sof_ignored_write", write_reg, wr(1'b1, exp_a, 4'h7));
        check("sof_ignored_err", 32'(frame_err), 32'h0);
`endif

        // Reset in the middle of a frame
        do_reset();
        for (int i = 0; i <= 5000; i++) begin
            drive(1'b1, i == 0, 4'(i));
            step();
        end
        check("pre_reset_write", write_reg, wr(1'b1, 20'd5000, 4'h8));
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("midreset");
        drive(1'b0, 1'b0, 4'h0);
        step();
        reset = 1'b1;
        drive(1'b1, 1'b0, 4'h3);
        step();
        check("post_reset_drop", write_reg, 32'h0);
        drive(1'b1, 1'b1, 4'h6);
        step();
        check("post_reset_sof", write_reg, wr(1'b1, 20'd0, 4'h6));
        check("post_reset_busy", 32'(busy), 32'h1);
        drive(1'b1, 1'b0, 4'h2);
        step();
        check("post_reset_next", write_reg, wr(1'b1, 20'd1, 4'h2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
